psum_accum_quant: RTL and testbench

//  Downstream of the 1x16 * 16x16 PE. Accumulates NUM_TILES successive 16-lane psum vectors
//  (one per K-tile) into ACC_W-bit lane accumulators, then requantizes each lane to int8:

---
 rtl/pe_pkg.sv | 25 ++
 rtl/psum_quant_lane.sv | 36 +++
 rtl/psum_accum_quant.sv | 98 +++++++++
 tb/tb_psum_accum_quant.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths, FSM state type and lane-slicing helper for the psum accumulate/quantize path.
package pe_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 8;

  // Saturation bounds, widened by one bit to hold the rounding carry.
  localparam logic signed [ACC_W:0] QMax = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] QMin = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  // Lane 0 lives in the most significant slice.
  function automatic logic [IN_W-1:0] lane_slice(input logic [LANES*IN_W-1:0] vec,
                                                 input int unsigned idx);
    return vec[(LANES - 1 - idx) * IN_W +: IN_W];
  endfunction

endpackage

// File: rtl/psum_quant_lane.sv
// Combinational requantizer for one lane: round-half-up shift, optional ReLU, int8 saturate.
module psum_quant_lane
  import pe_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] q_out
);

  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] clamped;

  always_comb begin
    bias = '0;
    if (shift != 5'd0) begin
      bias = (ACC_W + 1)'(1) << (shift - 5'd1);
    end
    rounded = {acc_in[ACC_W-1], acc_in} + bias;
    shifted = rounded >>> shift;
    clamped = shifted;
    if (relu_en && shifted[ACC_W]) begin
      clamped = '0;
    end
    if (clamped > QMax) begin
      q_out = QMax[OUT_W-1:0];
    end else if (clamped < QMin) begin
      q_out = QMin[OUT_W-1:0];
    end else begin
      q_out = clamped[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_accum_quant.sv
// Accumulates NUM_TILES psum vectors per lane, then emits one registered int8 vector
// over valid/ready.
module psum_accum_quant
  import pe_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [LANES*IN_W-1:0]  psum,
  input  logic [4:0]             shift,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy
);

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [ACC_W-1:0]        acc_q [LANES];
  logic [ACC_W-1:0]        acc_d [LANES];
  logic [ACC_W-1:0]        acc_sum [LANES];
  logic [LANES*OUT_W-1:0]  out_q, out_d;
  logic [LANES*OUT_W-1:0]  q_vec;
  logic                    beat;
  logic                    last_beat;

  // The first beat of a group starts from zero rather than the stale accumulator.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IN_W-1:0] lane_raw;
    assign lane_raw   = lane_slice(psum, i);
    assign acc_sum[i] = ((state_q == StIdle) ? '0 : acc_q[i]) +
                        {{(ACC_W - IN_W){lane_raw[IN_W-1]}}, lane_raw};

    psum_quant_lane u_quant (
      .acc_in  (acc_sum[i]),
      .shift   (shift),
      .relu_en (relu_en),
      .q_out   (q_vec[(LANES - 1 - i) * OUT_W +: OUT_W])
    );
  end

  assign psum_ready = (state_q != StOut);
  assign out_valid  = (state_q == StOut);
  assign busy       = (state_q != StIdle);
  assign out_data   = out_q;
  assign beat       = psum_valid && psum_ready;
  assign last_beat  = ((state_q == StIdle) && (NUM_TILES == 1)) ||
                      ((state_q == StAcc) && (cnt_q == 16'(NUM_TILES - 1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (beat) begin
          acc_d = acc_sum;
          cnt_d = (state_q == StIdle) ? 16'd1 : cnt_q + 16'd1;
          if (last_beat) begin
            state_d = StOut;
            out_d   = q_vec;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      out_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_quant.sv
// Scoreboard bench: driver pushes model results, a negedge monitor pops on each output handshake.
module tb_psum_accum_quant;

  localparam int NT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         psum_valid = 1'b0;
  logic         psum_ready;
  logic [255:0] psum = '0;
  logic [4:0]   shift = '0;
  logic         relu_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] sb[$];
  int           bp_mode = 1;  // 0 random out_ready, 1 held low, 2 held high
  int           beat_vals[NT][16];
  logic         hold_valid = 1'b0;
  logic [127:0] hold_data = '0;

  psum_accum_quant #(.NUM_TILES(NT)) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum       (psum),
    .shift      (shift),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer sums, then round/ReLU/saturate by arithmetic rules.
  function automatic logic [127:0] model(input int sh, input bit relu);
    logic [127:0] e;
    longint       sum;
    longint       r;
    e = '0;
    for (int l = 0; l < 16; l++) begin
      sum = 0;
      for (int b = 0; b < NT; b++) sum += longint'(beat_vals[b][l]);
      r = (sum + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0)) >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      e[127 - 8*l -: 8] = 8'(r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      hold_valid = 1'b0;
    end else if (out_valid) begin
      if (hold_valid) check("out_stable", out_data, hold_data);
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 128'd1, 128'd0);
        end else begin
          check("out_data", out_data, sb.pop_front());
        end
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        hold_data  = out_data;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic clear_vals();
    for (int b = 0; b < NT; b++) for (int l = 0; l < 16; l++) beat_vals[b][l] = 0;
  endtask

  task automatic random_vals();
    int range;
    range = ($urandom_range(0, 2) == 0) ? 127 : (($urandom_range(0, 1) == 0) ? 2000 : 32767);
    for (int b = 0; b < NT; b++)
      for (int l = 0; l < 16; l++)
        beat_vals[b][l] = int'($urandom_range(0, 2 * range)) - range;
  endtask

  // Called at a negedge; returns at the negedge right after the beat's clock edge.
  task automatic drive_beat(input int b, input int sh, input bit relu, input bit last);
    logic [255:0] v;
    int n;
    for (int l = 0; l < 16; l++) v[255 - 16*l -: 16] = 16'(beat_vals[b][l]);
    psum = v;
    shift = 5'(sh);
    relu_en = relu;
    psum_valid = 1'b1;
    n = 0;
    while (!psum_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!psum_ready) begin
      check("beat_timeout", 128'd0, 128'd1);
      psum_valid = 1'b0;
      return;
    end
    @(negedge clk);
    psum_valid = 1'b0;
    psum = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    shift = 5'($urandom);
    relu_en = 1'($urandom);
    if (last) check("latency_out_valid", 128'(out_valid), 128'd1);
  endtask

  task automatic send_group(input int sh, input bit relu, input bit gapped,
                            input bit use_exp, input logic [127:0] exp_v);
    sb.push_back(use_exp ? exp_v : model(sh, relu));
    for (int b = 0; b < NT; b++) begin
      if (b == NT - 1) begin
        drive_beat(b, sh, relu, 1'b1);
      end else begin
        drive_beat(b, int'($urandom_range(0, 31)), 1'($urandom), 1'b0);
        if (b == 0) check("busy_mid_group", 128'(busy), 128'd1);
        if (gapped) repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] snap;
    logic [127:0] e;

    // Reset
    rst = 1'b0;
    bp_mode = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_data", out_data, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_psum_ready", 128'(psum_ready), 128'd1);

    // All lanes 100 per beat, shift 2 -> 100
    bp_mode = 2;
    for (int b = 0; b < NT; b++) for (int l = 0; l < 16; l++) beat_vals[b][l] = 100;
    send_group(2, 1'b0, 1'b0, 1'b1, {16{8'h64}});
    wait_drain();

    // Saturation at shift 0
    clear_vals();
    for (int b = 0; b < NT; b++) begin
      beat_vals[b][0] = 75;
      beat_vals[b][1] = -75;
    end
    send_group(0, 1'b0, 1'b0, 1'b1, {8'h7f, 8'h80, {14{8'h00}}});
    wait_drain();

    // Round half up at shift 1: 3 -> 2, -3 -> -1, 5 -> 3
    clear_vals();
    for (int b = 0; b < 3; b++) begin
      beat_vals[b][0] = 1;
      beat_vals[b][1] = -1;
    end
    beat_vals[0][2] = 2;
    for (int b = 1; b < NT; b++) beat_vals[b][2] = 1;
    send_group(1, 1'b0, 1'b0, 1'b1, {8'h02, 8'hff, 8'h03, {13{8'h00}}});
    wait_drain();

    // ReLU: -5 -> 0, 5 stays 5
    clear_vals();
    beat_vals[0][0] = -2;
    beat_vals[0][1] = 2;
    for (int b = 1; b < NT; b++) begin
      beat_vals[b][0] = -1;
      beat_vals[b][1] = 1;
    end
    send_group(0, 1'b1, 1'b0, 1'b1, {8'h00, 8'h05, {14{8'h00}}});
    wait_drain();

    // Backpressure: output held, psum_valid ignored while out is pending
    bp_mode = 1;
    random_vals();
    send_group(4, 1'b0, 1'b0, 1'b0, '0);
    snap = out_data;
    for (int c = 0; c < 5; c++) begin
      psum_valid = 1'b1;
      psum = {8{$urandom}};
      @(negedge clk);
      check("bp_psum_ready_low", 128'(psum_ready), 128'd0);
      check("bp_out_data_hold", out_data, snap);
    end
    psum_valid = 1'b0;
    bp_mode = 2;
    wait_drain();
    @(negedge clk);
    check("bp_ready_returns", 128'(psum_ready), 128'd1);
    check("bp_valid_drops", 128'(out_valid), 128'd0);

    // Gapped input matches the gap-free run
    random_vals();
    e = model(3, 1'b0);
    send_group(3, 1'b0, 1'b0, 1'b1, e);
    wait_drain();
    send_group(3, 1'b0, 1'b1, 1'b1, e);
    wait_drain();

    // Reset mid-group after two beats discards the partial sum
    random_vals();
    drive_beat(0, 5, 1'b0, 1'b0);
    drive_beat(1, 5, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    random_vals();
    send_group(int'($urandom_range(0, 8)), 1'($urandom), 1'b0, 1'b0, '0);
    wait_drain();

    // Random groups with random backpressure
    bp_mode = 0;
    for (int g = 0; g < 40; g++) begin
      random_vals();
      send_group((g % 7 == 0) ? 31 : int'($urandom_range(0, 12)), 1'($urandom),
                 1'($urandom), 1'b0, '0);
    end
    bp_mode = 2;
    wait_drain();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
